fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch and program-counter stage of the single-cycle CPU, sitting directly upstream of the `CTRL` decoder. It owns the PC register, fetches words from instruction memory over a req/ack handshake, and holds the current instruction so `CTRL` sees a stable `op`/`func`. It consumes `CTRL`'s `prsource` to compute the next PC. It emits a one-cycle commit strobe that gates all architectural writes.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request, registered.
- `imem_addr` out 32: fetch address; always equals `pc`.
- `imem_ack` in 1: memory has `imem_rdata` valid this cycle.
- `imem_rdata` in 32: instruction word.
- `stall` in 1: hold the current instruction in EXEC; no commit.
- `prsource` in 2: next-PC select from `CTRL` (00 pc+4, 01 branch, 10 register, 11 jump).
- `ra` in 32: register-file rs value, used as the `jr` target.
- `inst` out 32: held instruction.
- `op` out 6: `inst[31:26]`, to `CTRL`.
- `func` out 6: `inst[5:0]`, to `CTRL`.
- `pc` out 32: address of the held instruction.
- `pc_plus4` out 32: `pc` + 4, used as the `jal` link value.
- `inst_valid` out 1: commit strobe. Register-file and data-memory writes are qualified by it.
- `retired` out 32: count of committed instructions.

## Operation
- FSM states: IDLE, FETCH, EXEC.
- **Reset values** (async, immediate):
  - state = IDLE, `pc` = `RESET_PC`.
  - `inst` = 0, so `op` = 0 and `func` = 0.
  - `imem_req` = 0, `inst_valid` = 0, `retired` = 0.
- **IDLE**: moves unconditionally to FETCH on the next edge.
- **FETCH**:
  - `imem_req` = 1.
  - `imem_ack` = 1 → `inst` <= `imem_rdata`, go to EXEC.
  - Otherwise stay in FETCH; `inst` is unchanged.
- **EXEC**:
  - `inst_valid` = `!stall`, combinational from state and `stall`.
  - If `!stall`:
    - `pc` <= next_pc.
    - `retired` <= `retired` + 1.
    - Go to FETCH.
  - If `stall`: everything holds.
- **next_pc** (from `prsource`):
  - 00: `pc_plus4`.
  - 01: `pc_plus4` + {{14{inst[15]}}, inst[15:0], 2'b00}.
  - 10: {ra[31:2], 2'b00}.
  - 11: {pc_plus4[31:28], inst[25:0], 2'b00}.
- **Arithmetic**: all adds are modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0. `retired` wraps from 32'hFFFF_FFFF to 0.
- **Branch condition**: `CTRL` has already folded `z` into `prsource`. This block does not inspect `z`.
- **Boundary conditions**:
  - `imem_ack` outside FETCH is ignored.
  - `stall` outside EXEC is ignored.
  - `imem_rdata` is sampled only on the ack cycle.

## Timing
- Minimum 2 cycles per instruction: FETCH with same-cycle ack, then EXEC.
- Each ack-wait cycle adds 1; each stall cycle adds 1.
- The new `pc` is visible the cycle after the commit, in FETCH, with `imem_req` = 1.
- `op`/`func` change only on the edge that leaves FETCH. They are stable throughout EXEC, so `CTRL` outputs settle within EXEC.
- `imem_req` is driven from registered state: high for every FETCH cycle, low in IDLE and EXEC.
- Reset asserted mid-FETCH or mid-EXEC:
  - `imem_req` and `inst_valid` drop asynchronously.
  - No partial commit.
  - After release: one IDLE cycle, then a fetch from `RESET_PC`.

## Structure
- Shared `cpu_pkg`:
  - `prsource` encodings `PRS_NEXT`/`PRS_BRANCH`/`PRS_JR`/`PRS_JUMP`.
  - FSM state encoding.
  - Default `RESET_PC`.
  - Opcode/func field positions.
- One combinational sub-module, `next_pc`: inputs `pc_plus4`, `inst`, `ra`, `prsource`; output the 32-bit target.
- The FSM, PC, instruction register and counter stay in `fetch_unit`.

## Test plan
- **Reset then straight-line fetch**: `imem_ack` tied 1, `prsource`=00.
  - `imem_addr` sequence 0,4,8.
  - `inst_valid` pulses every 2nd cycle.
  - `retired`=3 after third commit.
- **Branch**: at `pc`=0x10, `inst`=0x1000FFFE, `prsource`=01 → next `imem_addr`=0x0C.
- **Jump / jr**:
  - `inst`=0x08000040, `pc`=0x1000_0000, `prsource`=11 → next 0x1000_0100.
  - `prsource`=10, `ra`=0x0000_0203 → next 0x0000_0200.
- **Wait and stall**:
  - `imem_ack` delayed 3 cycles → `imem_req` stays high 4 cycles and `inst` is unchanged until ack.
  - `stall` high 2 cycles in EXEC → `inst_valid` low, `pc` held, then commit.
- **Reset mid-EXEC**: `rst_n` low while `pc`=0x20 in EXEC.
  - Immediately `pc`=`RESET_PC`, `inst_valid`=0, `retired`=0.
  - First request after release is to `RESET_PC`.
- **Wrap**: `pc`=0xFFFF_FFFC, `prsource`=00 → next `imem_addr`=0x0000_0000.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU encodings: next-PC selects, fetch FSM states, field positions
package cpu_pkg;

  typedef enum logic [1:0] {
    PRS_NEXT   = 2'b00,
    PRS_BRANCH = 2'b01,
    PRS_JR     = 2'b10,
    PRS_JUMP   = 2'b11
  } prsource_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 26;
  localparam int FUNC_MSB = 5;
  localparam int FUNC_LSB = 0;

  // Word-aligned, sign-extended branch displacement.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory req/ack bus
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_unit_next_pc.sv
// rtl/fetch_unit_next_pc.sv - combinational next-PC target select
module next_pc
  import cpu_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [31:0] inst,
  input  logic [31:0] ra,
  input  logic [1:0]  prsource,
  output logic [31:0] target
);

  logic unused_bits;
  assign unused_bits = ^{inst[31:26], ra[1:0]};

  always_comb begin
    target = pc_plus4;
    case (prsource)
      PRS_NEXT:   target = pc_plus4;
      PRS_BRANCH: target = pc_plus4 + branch_offset(inst[15:0]);
      PRS_JR:     target = {ra[31:2], 2'b00};
      PRS_JUMP:   target = {pc_plus4[31:28], inst[25:0], 2'b00};
      default:    target = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register, instruction fetch FSM and commit strobe
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
  input  logic                clk,
  input  logic                rst_n,
  fetch_unit_if.master        imem,
  input  logic                stall,
  input  logic [1:0]          prsource,
  input  logic [31:0]         ra,
  output logic [31:0]         inst,
  output logic [5:0]          op,
  output logic [5:0]          func,
  output logic [31:0]         pc,
  output logic [31:0]         pc_plus4,
  output logic                inst_valid,
  output logic [31:0]         retired
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  inst_q;
  logic [31:0]  retired_q;
  logic         req_q;
  logic [31:0]  target;

  assign pc_plus4 = pc_q + 32'd4;

  next_pc u_next_pc (
    .pc_plus4 (pc_plus4),
    .inst     (inst_q),
    .ra       (ra),
    .prsource (prsource),
    .target   (target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      retired_q <= '0;
      req_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_FETCH;
          req_q   <= 1'b1;
        end
        ST_FETCH: begin
          if (imem.ack) begin
            inst_q  <= imem.rdata;
            state_q <= ST_EXEC;
            req_q   <= 1'b0;
          end
        end
        ST_EXEC: begin
          // A stalled instruction keeps PC, counter and state untouched.
          if (!stall) begin
            pc_q      <= target;
            retired_q <= retired_q + 32'd1;
            state_q   <= ST_FETCH;
            req_q     <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign inst_valid = (state_q == ST_EXEC) && !stall;

  assign imem.req  = req_q;
  assign imem.addr = pc_q;

  assign inst    = inst_q;
  assign op      = inst_q[OP_MSB:OP_LSB];
  assign func    = inst_q[FUNC_MSB:FUNC_LSB];
  assign pc      = pc_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [1:0]  prsource;
  logic [31:0] ra;
  logic [31:0] inst;
  logic [5:0]  op;
  logic [5:0]  func;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        inst_valid;
  logic [31:0] retired;

  fetch_unit_if imem_bus ();

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem       (imem_bus),
    .stall      (stall),
    .prsource   (prsource),
    .ra         (ra),
    .inst       (inst),
    .op         (op),
    .func       (func),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .inst_valid (inst_valid),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_ret;

  bit          want_addr_en = 0;
  logic [31:0] want_addr;
  string       want_tag;
  bit          want_ret_en = 0;
  logic [31:0] want_ret;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_target(input logic [31:0] p, input logic [31:0] w,
                                             input logic [1:0] prs, input logic [31:0] r);
    logic [31:0]        p4;
    logic signed [15:0] imm16;
    logic signed [31:0] off;
    logic [31:0]        idx;
    p4    = p + 32'd4;
    imm16 = w[15:0];
    off   = imm16;
    idx   = {6'b0, w[25:0]};
    case (prs)
      2'd0:    return p4;
      2'd1:    return p4 + 32'(off * 4);
      2'd2:    return r - (r % 32'd4);
      default: return (p4 & 32'hF000_0000) + idx * 32'd4;
    endcase
  endfunction

  // One instruction: d ack-wait cycles, s stall cycles, then commit.
  task automatic run_instr(input int d, input logic [31:0] w, input int s,
                           input logic [1:0] prs, input logic [31:0] rav);
    for (int i = 0; i <= d; i++) begin
      imem_bus.ack   = (i == d);
      imem_bus.rdata = (i == d) ? w : $urandom;
      stall          = 1'($urandom_range(0, 1));
      prsource       = 2'($urandom);
      ra             = $urandom;
      @(negedge clk);
      if (i == 0 && want_addr_en) begin
        check_eq(want_tag, imem_bus.addr, want_addr);
        want_addr_en = 0;
      end
      if (i == 0 && want_ret_en) begin
        check_eq("retired_count", retired, want_ret);
        want_ret_en = 0;
      end
      check_eq("fetch_req", 32'(imem_bus.req), 32'd1);
      check_eq("fetch_addr", imem_bus.addr, m_pc);
      check_eq("fetch_inst_hold", inst, m_inst);
      check_eq("fetch_valid", 32'(inst_valid), 32'd0);
      check_eq("fetch_retired", retired, m_ret);
      step();
    end
    m_inst = w;
    for (int j = 0; j <= s; j++) begin
      imem_bus.ack   = 1'($urandom_range(0, 1));
      imem_bus.rdata = $urandom;
      stall          = (j < s);
      prsource       = prs;
      ra             = rav;
      @(negedge clk);
      check_eq("exec_req", 32'(imem_bus.req), 32'd0);
      check_eq("exec_inst", inst, w);
      check_eq("exec_op", 32'(op), w >> 26);
      check_eq("exec_func", 32'(func), w & 32'h3F);
      check_eq("exec_pc", pc, m_pc);
      check_eq("exec_pc4", pc_plus4, m_pc + 32'd4);
      check_eq("exec_valid", 32'(inst_valid), 32'(j == s));
      check_eq("exec_retired", retired, m_ret);
      step();
    end
    m_pc  = ref_target(m_pc, w, prs, rav);
    m_ret = m_ret + 32'd1;
    stall = 1'b0;
    imem_bus.ack = 1'b0;
  endtask

  task automatic expect_addr(input string tag, input logic [31:0] a);
    want_addr_en = 1;
    want_addr    = a;
    want_tag     = tag;
  endtask

  initial begin
    rst_n          = 1'b0;
    stall          = 1'b0;
    prsource       = 2'd0;
    ra             = '0;
    imem_bus.ack   = 1'b0;
    imem_bus.rdata = '0;
    m_pc   = 32'h0;
    m_inst = 32'h0;
    m_ret  = 32'h0;
    #1;
    check_eq("rst_req", 32'(imem_bus.req), 32'd0);
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_addr", imem_bus.addr, 32'h0);
    check_eq("rst_inst", inst, 32'h0);
    check_eq("rst_op", 32'(op), 32'h0);
    check_eq("rst_func", 32'(func), 32'h0);
    check_eq("rst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_retired", retired, 32'h0);

    step();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_req", 32'(imem_bus.req), 32'd0);
    step();

    // Straight-line fetch with same-cycle ack.
    expect_addr("line_addr0", 32'h0);
    run_instr(0, $urandom, 0, 2'd0, $urandom);
    expect_addr("line_addr1", 32'h4);
    run_instr(0, $urandom, 0, 2'd0, $urandom);
    expect_addr("line_addr2", 32'h8);
    run_instr(0, $urandom, 0, 2'd0, $urandom);
    want_ret_en = 1;
    want_ret    = 32'd3;

    // Branch backwards from 0x10.
    run_instr(0, $urandom, 0, 2'd2, 32'h13);
    expect_addr("branch_from", 32'h10);
    run_instr(0, 32'h1000_FFFE, 0, 2'd1, $urandom);
    expect_addr("branch_addr", 32'h0C);

    // Jump and jr.
    run_instr(0, $urandom, 0, 2'd2, 32'h1000_0000);
    expect_addr("jump_from", 32'h1000_0000);
    run_instr(0, 32'h0800_0040, 0, 2'd3, $urandom);
    expect_addr("jump_addr", 32'h1000_0100);
    run_instr(0, $urandom, 0, 2'd2, 32'h0000_0203);
    expect_addr("jr_addr", 32'h0000_0200);

    // Ack delayed 3 cycles, then 2 stall cycles.
    run_instr(3, $urandom, 2, 2'd0, $urandom);
    expect_addr("wait_stall_addr", 32'h0000_0204);

    // PC wrap.
    run_instr(0, $urandom, 0, 2'd2, 32'hFFFF_FFFF);
    expect_addr("wrap_from", 32'hFFFF_FFFC);
    run_instr(0, $urandom, 0, 2'd0, $urandom);
    expect_addr("wrap_addr", 32'h0);

    for (int k = 0; k < 60; k++) begin
      run_instr(int'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 2)),
                2'($urandom), $urandom);
    end

    // Reset while stalled in EXEC at pc 0x20.
    run_instr(0, $urandom, 0, 2'd2, 32'h20);
    imem_bus.ack   = 1'b1;
    imem_bus.rdata = $urandom;
    @(negedge clk);
    check_eq("pre_rst_addr", imem_bus.addr, 32'h20);
    step();
    imem_bus.ack = 1'b0;
    stall = 1'b1;
    @(negedge clk);
    check_eq("pre_rst_exec_pc", pc, 32'h20);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_pc", pc, 32'h0);
    check_eq("mid_rst_valid", 32'(inst_valid), 32'd0);
    check_eq("mid_rst_req", 32'(imem_bus.req), 32'd0);
    check_eq("mid_rst_retired", retired, 32'h0);
    check_eq("mid_rst_inst", inst, 32'h0);
    step();
    rst_n = 1'b1;
    stall = 1'b0;
    m_pc   = 32'h0;
    m_inst = 32'h0;
    m_ret  = 32'h0;
    @(negedge clk);
    check_eq("post_rst_idle_req", 32'(imem_bus.req), 32'd0);
    step();
    expect_addr("post_rst_addr", 32'h0);
    run_instr(1, $urandom, 1, 2'd0, $urandom);
    run_instr(0, $urandom, 0, 2'd0, $urandom);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
